ucode_ctrl_seq: RTL and testbench

Parametrised, writable microcode control store with a built-in microsequencer. It replaces the fixed combinational control ROM in the decode stage. The decoder presents an entry address. The block then streams one or more registered control words (multi-cycle micro-ops), advancing through consecutive addresses until a word flagged "last". Entries are loaded at boot or runtime through a programming port. Reads of unprogrammed entries are flagged rather than silently undefined.

---
 rtl/ucode_ctrl_seq_if.sv | 31 +++
 rtl/ucode_ctrl_seq.sv | 113 +++++++++++
 tb/tb_ucode_ctrl_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ucode_ctrl_seq_if.sv
// Programming, request and control-word handshake bundle for the microcode sequencer.
// The master side is the decoder/datapath and the slave side is the control store.
interface ucode_ctrl_seq_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 20
);
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              prog_last;
    logic              prog_ready;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              ctrl_valid;
    logic              ctrl_ready;
    logic [DATA_W-1:0] ctrl_data;
    logic              ctrl_last;
    logic              ctrl_err;
    logic              busy;

    modport master (
        output prog_we, prog_addr, prog_data, prog_last, req_valid, req_addr, ctrl_ready,
        input  prog_ready, req_ready, ctrl_valid, ctrl_data, ctrl_last, ctrl_err, busy
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, prog_last, req_valid, req_addr, ctrl_ready,
        output prog_ready, req_ready, ctrl_valid, ctrl_data, ctrl_last, ctrl_err, busy
    );
endinterface

// File: rtl/ucode_ctrl_seq.sv
// Writable microcode control store with a sequencer that streams registered control
// words from an entry address until a word flagged last; unprogrammed reads are flagged.
//
// state  | meaning
// IDLE   | no word in the output register, store may be programmed
// RUN    | output register holds a control word awaiting transfer
module ucode_ctrl_seq #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64,
    parameter int DATA_W = 20
) (
    input logic            clk,
    input logic            rst_n,
    ucode_ctrl_seq_if.slave bus
);
    typedef enum logic {S_IDLE, S_RUN} state_e;

    // One extra address bit so that stepping past DEPTH-1 is seen as out of range.
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [DATA_W:0]   mem_q [DEPTH];
    logic [DEPTH-1:0]  pgm_q;
    logic [ADDR_W:0]   addr_q;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              err_q, err_d;

    logic              run;
    logic              transfer;
    logic              prog_rdy;
    logic              accept;
    logic              wr_en;
    logic              load;
    logic              hit;
    logic [ADDR_W:0]   fetch_addr;
    logic [ADDR_W-1:0] fetch_idx;
    logic [DATA_W:0]   word;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_RUN;
            S_RUN:  if (transfer && last_q && !accept) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        run      = (state_q == S_RUN);
        transfer = run & bus.ctrl_ready;
        prog_rdy = ~run | (last_q & transfer);
    end

    assign bus.ctrl_valid = run;
    assign bus.busy       = run;
    assign bus.prog_ready = prog_rdy;
    assign bus.req_ready  = prog_rdy & ~bus.prog_we;
    assign bus.ctrl_data  = data_q;
    assign bus.ctrl_last  = last_q;
    assign bus.ctrl_err   = err_q;

    assign accept = bus.req_valid & bus.req_ready;
    assign wr_en  = bus.prog_we & prog_rdy & ({1'b0, bus.prog_addr} < DEPTH_W);
    assign load   = accept | (transfer & ~last_q);

    // A miss (unprogrammed or beyond the store) becomes a terminating error word.
    always_comb begin
        fetch_addr = accept ? {1'b0, bus.req_addr} : addr_q + 1'b1;
        fetch_idx  = fetch_addr[ADDR_W-1:0];
        hit        = (fetch_addr < DEPTH_W) && pgm_q[fetch_idx];
        word       = mem_q[fetch_idx];
        data_d     = '0;
        last_d     = 1'b1;
        err_d      = 1'b1;
        if (hit) begin
            data_d = word[DATA_W-1:0];
            last_d = word[DATA_W];
            err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            data_q <= '0;
            last_q <= 1'b0;
            err_q  <= 1'b0;
            pgm_q  <= '0;
        end else begin
            if (load) begin
                addr_q <= fetch_addr;
                data_q <= data_d;
                last_q <= last_d;
                err_q  <= err_d;
            end else if (state_d == S_IDLE) begin
                data_q <= '0;
                last_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (wr_en) pgm_q[bus.prog_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[bus.prog_addr] <= {bus.prog_last, bus.prog_data};
    end
endmodule

// File: tb/tb_ucode_ctrl_seq.sv
// Directed bench for the microcode sequencer: expected words are queued at request
// time and a negedge monitor compares every presented word against the queue head.
module tb_ucode_ctrl_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    logic [21:0] exp_q [$];

    localparam logic [19:0] WA = 20'hA0A0A;
    localparam logic [19:0] WB = 20'hB1B1B;
    localparam logic [19:0] WC = 20'hC2C2C;
    localparam logic [21:0] ERRW = {20'h0, 1'b1, 1'b1};

    always #5 clk = ~clk;

    ucode_ctrl_seq_if #(.ADDR_W(6), .DATA_W(20)) bus ();

    ucode_ctrl_seq #(.ADDR_W(6), .DEPTH(64), .DATA_W(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: a held word must match the queue head; the head is retired on transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.ctrl_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got %h expected none",
                             {bus.ctrl_data, bus.ctrl_last, bus.ctrl_err});
                end else begin
                    check("ctrl_word", {10'h0, bus.ctrl_data, bus.ctrl_last, bus.ctrl_err}, {10'h0, exp_q[0]});
                    if (bus.ctrl_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic prog(input logic [5:0] a, input logic [19:0] d, input logic l);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        bus.prog_last = l;
        @(posedge clk); #1;
        bus.prog_we = 1'b0;
    endtask

    task automatic req(input logic [5:0] a);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (bus.busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check(nm, {31'h0, bus.busy}, 32'h0);
    endtask

    task automatic push_abc();
        exp_q.push_back({WA, 1'b0, 1'b0});
        exp_q.push_back({WB, 1'b0, 1'b0});
        exp_q.push_back({WC, 1'b1, 1'b0});
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.prog_we    = 1'b0;
        bus.prog_addr  = '0;
        bus.prog_data  = '0;
        bus.prog_last  = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.ctrl_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'h0, bus.ctrl_valid}, 32'h0);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_data", {12'h0, bus.ctrl_data}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_prog_ready", {31'h0, bus.prog_ready}, 32'h1);
        check("idle_req_ready", {31'h0, bus.req_ready}, 32'h1);

        // single-word entry
        prog(6'd5, 20'h12345, 1'b1);
        exp_q.push_back({20'h12345, 1'b1, 1'b0});
        req(6'd5);
        check("latency_valid", {31'h0, bus.ctrl_valid}, 32'h1);
        check("latency_busy", {31'h0, bus.busy}, 32'h1);
        wait_idle("single_idle");

        // three-word gapless stream
        prog(6'd10, WA, 1'b0);
        prog(6'd11, WB, 1'b0);
        prog(6'd12, WC, 1'b1);
        push_abc();
        req(6'd10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stream_busy", {31'h0, bus.busy}, 32'h1);
        end
        @(negedge clk);
        check("stream_end_valid", {31'h0, bus.ctrl_valid}, 32'h0);
        @(posedge clk); #1;

        // stall on B for three cycles
        push_abc();
        req(6'd10);
        @(posedge clk); #1;
        bus.ctrl_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stall_prog_ready", {31'h0, bus.prog_ready}, 32'h0);
        bus.ctrl_ready = 1'b1;
        wait_idle("stall_idle");
        check("stall_queue_empty", exp_q.size(), 32'h0);

        // unprogrammed entry
        exp_q.push_back(ERRW);
        req(6'd20);
        wait_idle("unprog_idle");

        // top entry runs off the end of the store
        prog(6'd63, 20'h5A5A5, 1'b0);
        exp_q.push_back({20'h5A5A5, 1'b0, 1'b0});
        exp_q.push_back(ERRW);
        req(6'd63);
        wait_idle("wrap_idle");

        // programming beats a simultaneous request
        bus.prog_we   = 1'b1;
        bus.prog_addr = 6'd30;
        bus.prog_data = 20'h3C3C3;
        bus.prog_last = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 6'd5;
        @(negedge clk);
        check("prio_req_ready", {31'h0, bus.req_ready}, 32'h0);
        check("prio_prog_ready", {31'h0, bus.prog_ready}, 32'h1);
        @(posedge clk); #1;
        bus.prog_we   = 1'b0;
        bus.req_valid = 1'b0;
        check("prio_no_start", {31'h0, bus.busy}, 32'h0);
        exp_q.push_back({20'h3C3C3, 1'b1, 1'b0});
        req(6'd30);
        wait_idle("prio_idle");

        // write attempted while a non-last word is held is dropped
        push_abc();
        bus.ctrl_ready = 1'b0;
        req(6'd10);
        bus.prog_we   = 1'b1;
        bus.prog_addr = 6'd11;
        bus.prog_data = 20'hBADBA;
        bus.prog_last = 1'b1;
        @(negedge clk);
        check("run_prog_ready", {31'h0, bus.prog_ready}, 32'h0);
        @(posedge clk); #1;
        bus.prog_we    = 1'b0;
        bus.ctrl_ready = 1'b1;
        wait_idle("run_write_idle");

        // reset while the second word is presented
        exp_q.push_back({WA, 1'b0, 1'b0});
        exp_q.push_back({WB, 1'b0, 1'b0});
        req(6'd10);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_valid", {31'h0, bus.ctrl_valid}, 32'h0);
        check("abort_busy", {31'h0, bus.busy}, 32'h0);
        check("abort_out", {10'h0, bus.ctrl_data, bus.ctrl_last, bus.ctrl_err}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_queue_empty", exp_q.size(), 32'h0);
        exp_q.push_back(ERRW);
        req(6'd5);
        wait_idle("cleared_idle");
        check("final_queue_empty", exp_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
